// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, EX-stage control bundle and slot modes for the ID/EX register
package pipeline_pkg;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int DATA_WIDTH = 16;
   localparam int ALU_OP_WIDTH = 4;
   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic [ALU_OP_WIDTH-1:0] aluOp;
   } ctrl_t;
   localparam ctrl_t BUBBLE_CTRL = '0;
   typedef enum logic [1:0] {RUN, BUBBLE, HOLD} mode_t;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a decode-stage read of a register still being loaded in EX
module load_use_detector #(
   parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH
) (
   input  logic                      ex_valid,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt,
   output logic                      hazard
);
   // r0 is hardwired, so a load targeting it can never feed a consumer
   assign hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != '0) &
                   ((ex_rd == id_rs) | (ex_rd == id_rt));
endmodule

// File: rtl/id_ex_hazard_register.sv
// id_ex_hazard_register: ID/EX pipeline register with load-use stall, flush and memory freeze.
// Optional STALL_COUNT_EN adds a saturating stallCycleCount output.
module id_ex_hazard_register #(
   parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = pipeline_pkg::REG_ADDR_WIDTH,
   parameter int ALU_OP_WIDTH = pipeline_pkg::ALU_OP_WIDTH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [REG_ADDR_WIDTH-1:0] ifIdRs,
   input  logic [REG_ADDR_WIDTH-1:0] ifIdRt,
   input  logic [REG_ADDR_WIDTH-1:0] ifIdRd,
   input  logic [DATA_WIDTH-1:0]     ifIdReadData1,
   input  logic [DATA_WIDTH-1:0]     ifIdReadData2,
   input  logic [DATA_WIDTH-1:0]     ifIdImmediate,
   input  logic                      ifIdRegWrite,
   input  logic                      ifIdMemRead,
   input  logic                      ifIdMemWrite,
   input  logic [ALU_OP_WIDTH-1:0]   ifIdAluOp,
   input  logic                      ifIdValid,
   input  logic                      flush,
   input  logic                      memBusy,
   output logic [REG_ADDR_WIDTH-1:0] idExRs,
   output logic [REG_ADDR_WIDTH-1:0] idExRt,
   output logic [REG_ADDR_WIDTH-1:0] idExRd,
   output logic [DATA_WIDTH-1:0]     idExReadData1,
   output logic [DATA_WIDTH-1:0]     idExReadData2,
   output logic [DATA_WIDTH-1:0]     idExImmediate,
   output logic                      idExRegWrite,
   output logic                      idExMemRead,
   output logic                      idExMemWrite,
   output logic [ALU_OP_WIDTH-1:0]   idExAluOp,
   output logic                      idExValid,
   output logic                      pcWriteEnable,
   output logic                      ifIdWriteEnable
`ifdef STALL_COUNT_EN
   ,
   output logic [15:0]               stallCycleCount
`endif
);
   import pipeline_pkg::*;
   logic  hazard;
   mode_t mode;
   ctrl_t ctrl;
   ctrl_t ctrl_in;
   load_use_detector #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_detect (
      .ex_valid(idExValid),
      .ex_mem_read(idExMemRead),
      .ex_rd(idExRd),
      .id_valid(ifIdValid),
      .id_rs(ifIdRs),
      .id_rt(ifIdRt),
      .hazard(hazard)
   );
   assign ctrl_in = {ifIdRegWrite, ifIdMemRead, ifIdMemWrite, ifIdAluOp};
   assign {idExRegWrite, idExMemRead, idExMemWrite, idExAluOp} = ctrl;
   // flush outranks the freeze so a redirect is never lost while memory is busy
   always_comb mode = flush ? BUBBLE : memBusy ? HOLD : hazard ? BUBBLE : RUN;
   assign pcWriteEnable = ~((hazard | memBusy) & ~flush);
   assign ifIdWriteEnable = pcWriteEnable;
   always_ff @(posedge clk)
      if (reset || mode == BUBBLE) begin
         idExRs        <= '0;
         idExRt        <= '0;
         idExRd        <= '0;
         idExReadData1 <= '0;
         idExReadData2 <= '0;
         idExImmediate <= '0;
         ctrl          <= BUBBLE_CTRL;
         idExValid     <= 1'b0;
      end else if (mode == RUN) begin
         idExRs        <= ifIdRs;
         idExRt        <= ifIdRt;
         idExRd        <= ifIdRd;
         idExReadData1 <= ifIdReadData1;
         idExReadData2 <= ifIdReadData2;
         idExImmediate <= ifIdImmediate;
         ctrl          <= ctrl_in;
         idExValid     <= ifIdValid;
      end
`ifdef STALL_COUNT_EN
   always_ff @(posedge clk)
      if (reset)
         stallCycleCount <= '0;
      else if (!pcWriteEnable && stallCycleCount != 16'hFFFF)
         stallCycleCount <= stallCycleCount + 16'd1;
`endif
endmodule

// File: tb/tb_id_ex_hazard_register.sv
// tb_id_ex_hazard_register: directed vector table, hand-written corner sequences and a randomized model check
module tb_id_ex_hazard_register;
   typedef struct packed {
      logic v, rw, mr, mw;
      logic [3:0] alu;
      logic [4:0] rs, rt, rd;
      logic [15:0] d1, d2, imm;
   } slot_t;
   typedef struct {
      logic rst, fl, busy, pcwe;
      slot_t in, exp;
   } vec_t;
   logic clk = 0, reset, flush, memBusy;
   slot_t in, dut;
   logic [4:0] idExRs, idExRt, idExRd;
   logic [15:0] idExReadData1, idExReadData2, idExImmediate;
   logic idExRegWrite, idExMemRead, idExMemWrite, idExValid, pcWriteEnable, ifIdWriteEnable;
   logic [3:0] idExAluOp;
   int passed = 0, total = 0;
`ifdef STALL_COUNT_EN
   logic [15:0] stallCycleCount;
`endif
   always #5 clk = ~clk;
   id_ex_hazard_register dut_i (
      .clk(clk), .reset(reset),
      .ifIdRs(in.rs), .ifIdRt(in.rt), .ifIdRd(in.rd),
      .ifIdReadData1(in.d1), .ifIdReadData2(in.d2), .ifIdImmediate(in.imm),
      .ifIdRegWrite(in.rw), .ifIdMemRead(in.mr), .ifIdMemWrite(in.mw),
      .ifIdAluOp(in.alu), .ifIdValid(in.v), .flush(flush), .memBusy(memBusy),
      .idExRs(idExRs), .idExRt(idExRt), .idExRd(idExRd),
      .idExReadData1(idExReadData1), .idExReadData2(idExReadData2), .idExImmediate(idExImmediate),
      .idExRegWrite(idExRegWrite), .idExMemRead(idExMemRead), .idExMemWrite(idExMemWrite),
      .idExAluOp(idExAluOp), .idExValid(idExValid),
      .pcWriteEnable(pcWriteEnable), .ifIdWriteEnable(ifIdWriteEnable)
`ifdef STALL_COUNT_EN
      , .stallCycleCount(stallCycleCount)
`endif
   );
   assign dut = {idExValid, idExRegWrite, idExMemRead, idExMemWrite, idExAluOp,
                 idExRs, idExRt, idExRd, idExReadData1, idExReadData2, idExImmediate};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic slot_t mk(input logic v, rw, mr, input int rs, rt, rd, alu);
      slot_t s;
      s = '0;
      s.v = v; s.rw = rw; s.mr = mr;
      s.rs = 5'(rs); s.rt = 5'(rt); s.rd = 5'(rd); s.alu = 4'(alu);
      return s;
   endfunction

   function automatic vec_t row(input logic rst, fl, busy, v, rw, mr, input int rs, rt, rd, alu,
                                input logic pcwe, ev, erw, emr, input int ers, ert, erd, ealu);
      vec_t r;
      r.rst = rst; r.fl = fl; r.busy = busy; r.pcwe = pcwe;
      r.in = mk(v, rw, mr, rs, rt, rd, alu);
      r.exp = mk(ev, erw, emr, ers, ert, erd, ealu);
      return r;
   endfunction

   vec_t tbl[$];
   slot_t m, prog[4];
   logic haz, exp_pcwe;
   int cnt, pc, stalls, cycles;

   initial begin
      tbl.push_back(row(0,0,0, 1,1,1,  1, 2, 3, 0, 1, 1,1,1,  1, 2, 3, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  3, 4, 5, 1, 0, 0,0,0,  0, 0, 0, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  3, 4, 5, 1, 1, 1,1,0,  3, 4, 5, 1));
      tbl.push_back(row(0,0,0, 1,1,1,  6, 0, 0, 0, 1, 1,1,1,  6, 0, 0, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  7, 0, 8, 3, 1, 1,1,0,  7, 0, 8, 3));
      tbl.push_back(row(0,0,0, 1,1,0,  1, 1, 5, 2, 1, 1,1,0,  1, 1, 5, 2));
      tbl.push_back(row(0,0,0, 1,1,0,  5, 9,10, 4, 1, 1,1,0,  5, 9,10, 4));
      tbl.push_back(row(0,0,0, 1,1,1,  2, 2, 3, 0, 1, 1,1,1,  2, 2, 3, 0));
      tbl.push_back(row(0,1,1, 1,1,0,  3, 3, 6, 5, 1, 0,0,0,  0, 0, 0, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  4, 5,11, 2, 1, 1,1,0,  4, 5,11, 2));
      for (int k = 0; k < 3; k++)
         tbl.push_back(row(0,0,1, 1,1,1, 11,11,12, 7, 0, 1,1,0,  4, 5,11, 2));
      tbl.push_back(row(0,0,0, 1,1,1, 11,11,12, 7, 1, 1,1,1, 11,11,12, 7));
      tbl.push_back(row(0,0,0, 0,0,0, 12,12,13, 0, 1, 0,0,0, 12,12,13, 0));
      tbl.push_back(row(0,0,0, 1,1,1,  1, 1, 3, 0, 1, 1,1,1,  1, 1, 3, 0));
      tbl.push_back(row(1,0,0, 1,1,0,  3, 0, 4, 1, 0, 0,0,0,  0, 0, 0, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  3, 0, 4, 1, 1, 1,1,0,  3, 0, 4, 1));
      tbl.push_back(row(0,0,0, 1,1,1,  1, 1, 7, 0, 1, 1,1,1,  1, 1, 7, 0));
      tbl.push_back(row(0,0,1, 1,1,0,  7, 0, 9, 1, 0, 1,1,1,  1, 1, 7, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  7, 0, 9, 1, 0, 0,0,0,  0, 0, 0, 0));
      tbl.push_back(row(0,0,0, 1,1,0,  7, 0, 9, 1, 1, 1,1,0,  7, 0, 9, 1));

      reset = 1; flush = 0; memBusy = 0; in = '0;
      tick(); tick();
      reset = 0;
      #1;
      chk("reset_state", dut, '0);
      chk("reset_pcwe", pcWriteEnable, 1'b1);

      foreach (tbl[i]) begin
         reset = tbl[i].rst; flush = tbl[i].fl; memBusy = tbl[i].busy; in = tbl[i].in;
         #1;
         chk($sformatf("vec%0d_pcwe", i), pcWriteEnable, tbl[i].pcwe);
         chk($sformatf("vec%0d_ifwe", i), ifIdWriteEnable, tbl[i].pcwe);
         tick();
         chk($sformatf("vec%0d_slot", i), dut, tbl[i].exp);
      end

      // back-to-back dependent loads through a tiny fetch model
      reset = 1; flush = 0; memBusy = 0; in = '0;
      tick();
      reset = 0;
      prog[0] = mk(1,1,1, 0,0,1, 0);
      prog[1] = mk(1,1,1, 1,0,2, 0);
      prog[2] = mk(1,1,1, 2,0,3, 0);
      prog[3] = mk(1,1,0, 3,3,4, 1);
      pc = 0; stalls = 0; cycles = 0;
      while (pc < 4 && cycles < 20) begin
         in = prog[pc];
         #1;
         exp_pcwe = pcWriteEnable;
         if (!exp_pcwe) stalls++;
         tick();
         cycles++;
         if (exp_pcwe) pc++;
      end
      chk("b2b_done", pc, 4);
      chk("b2b_stalls", stalls, 3);
      chk("b2b_cycles", cycles, 7);
`ifdef STALL_COUNT_EN
      chk("b2b_count", stallCycleCount, 16'd3);
`endif

      // randomized run against the priority-rule model
      reset = 1; in = '0;
      tick();
      m = '0; cnt = 0;
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         flush = ($urandom_range(0, 15) == 0);
         memBusy = ($urandom_range(0, 5) == 0);
         in.v = ($urandom_range(0, 7) != 0);
         in.rw = 1'($urandom); in.mr = 1'($urandom); in.mw = 1'($urandom);
         in.alu = 4'($urandom);
         in.rs = 5'($urandom_range(0, 3)); in.rt = 5'($urandom_range(0, 3)); in.rd = 5'($urandom_range(0, 3));
         in.d1 = 16'($urandom); in.d2 = 16'($urandom); in.imm = 16'($urandom);
         haz = m.v && m.mr && in.v && m.rd != 0 && (m.rd == in.rs || m.rd == in.rt);
         exp_pcwe = !((haz || memBusy) && !flush);
         #1;
         chk($sformatf("rnd%0d_pcwe", n), {pcWriteEnable, ifIdWriteEnable}, {exp_pcwe, exp_pcwe});
         tick();
         if (reset || flush || (!memBusy && haz)) m = '0;
         else if (!memBusy) m = in;
         cnt = reset ? 0 : (!exp_pcwe && cnt < 65535) ? cnt + 1 : cnt;
         chk($sformatf("rnd%0d_slot", n), dut, m);
`ifdef STALL_COUNT_EN
         chk($sformatf("rnd%0d_count", n), stallCycleCount, 16'(cnt));
`endif
      end

`ifdef STALL_COUNT_EN
      reset = 1; flush = 0; memBusy = 0; in = '0;
      tick();
      reset = 0;
      chk("cnt_reset", stallCycleCount, 16'd0);
      in = mk(1,1,1, 0,0,3, 0);
      tick();
      in = mk(1,1,0, 3,0,4, 1);
      tick();
      memBusy = 1;
      tick(); tick(); tick();
      memBusy = 0;
      #1;
      chk("cnt_four", stallCycleCount, 16'd4);
      memBusy = 1;
      for (int k = 0; k < 65540; k++) tick();
      chk("cnt_sat", stallCycleCount, 16'hFFFF);
      memBusy = 0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
